// File: rtl/axi_mdma_pkg.sv
// Shared types for the axi_mdma command/report side: AXI response codes and the
// job sequencer state encoding.
package axi_mdma_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/axi_mdma_seq_if.sv
// Job, command, report and completion handshakes of the axi_mdma job sequencer.
// The slave modport is the sequencer itself; master is the surrounding environment.
interface axi_mdma_seq_if #(
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned LENGTH_BITS     = 16,
  parameter int unsigned JOB_LENGTH_BITS = 32
);

  logic [ADDRESS_BITS-1:0]    job_src_addr;
  logic [ADDRESS_BITS-1:0]    job_dst_addr;
  logic [JOB_LENGTH_BITS-1:0] job_bytes;
  logic                       job_valid;
  logic                       job_ready;

  logic [ADDRESS_BITS-1:0]    cmd_src_addr;
  logic [ADDRESS_BITS-1:0]    cmd_dst_addr;
  logic [LENGTH_BITS-1:0]     cmd_bytes;
  logic                       cmd_valid;
  logic                       cmd_ready;

  logic [LENGTH_BITS-1:0]     rpt_bytes;
  logic [1:0]                 rpt_status;
  logic                       rpt_valid;
  logic                       rpt_ready;

  logic [JOB_LENGTH_BITS-1:0] done_bytes;
  logic [1:0]                 done_status;
  logic                       done_valid;
  logic                       done_ready;

  logic                       busy;

  modport slave (
    input  job_src_addr, job_dst_addr, job_bytes, job_valid,
    output job_ready,
    output cmd_src_addr, cmd_dst_addr, cmd_bytes, cmd_valid,
    input  cmd_ready,
    input  rpt_bytes, rpt_status, rpt_valid,
    output rpt_ready,
    output done_bytes, done_status, done_valid,
    input  done_ready,
    output busy
  );

  modport master (
    output job_src_addr, job_dst_addr, job_bytes, job_valid,
    input  job_ready,
    input  cmd_src_addr, cmd_dst_addr, cmd_bytes, cmd_valid,
    output cmd_ready,
    output rpt_bytes, rpt_status, rpt_valid,
    input  rpt_ready,
    input  done_bytes, done_status, done_valid,
    output done_ready,
    input  busy
  );

endinterface

// File: rtl/axi_mdma_seq.sv
// Splits one large copy job into axi_mdma commands of at most MAX_CMD_BYTES, keeps up to
// MAX_OUTSTANDING of them in flight and folds the per-command reports into one completion.
module axi_mdma_seq
  import axi_mdma_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS    = 32,
  parameter int unsigned LENGTH_BITS     = 16,
  parameter int unsigned JOB_LENGTH_BITS = 32,
  parameter int unsigned MAX_CMD_BYTES   = 4096,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic         aclk,
  input logic         aresetn,
  axi_mdma_seq_if.slave bus
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [JOB_LENGTH_BITS-1:0] MaxChunk = JOB_LENGTH_BITS'(MAX_CMD_BYTES);
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);

  seq_state_e state_q, state_d;

  logic [ADDRESS_BITS-1:0]    src_q, dst_q;
  logic [JOB_LENGTH_BITS-1:0] rem_q, rem_d;
  logic [JOB_LENGTH_BITS-1:0] chunk;
  logic [OutW-1:0]            out_q, out_d;
  logic                       err_q, err_d;
  logic [JOB_LENGTH_BITS-1:0] done_bytes_q;
  logic [1:0]                 done_status_q;

  logic job_ready, cmd_valid, done_valid, rpt_ready;
  logic job_hs, cmd_hs, rpt_hs, done_hs;

  // Command fields come straight from the job registers, so they cannot move while stalled.
  assign chunk     = (rem_q > MaxChunk) ? MaxChunk : rem_q;
  assign rpt_ready = (out_q != '0);

  assign job_hs  = bus.job_valid & job_ready;
  assign cmd_hs  = cmd_valid & bus.cmd_ready;
  assign rpt_hs  = bus.rpt_valid & rpt_ready;
  assign done_hs = done_valid & bus.done_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    rem_d = rem_q;
    if (job_hs) begin
      rem_d = bus.job_bytes;
    end else if (cmd_hs) begin
      rem_d = rem_q - chunk;
    end

    out_d = out_q;
    if (cmd_hs && !rpt_hs) begin
      out_d = out_q + 1'b1;
    end else if (!cmd_hs && rpt_hs) begin
      out_d = out_q - 1'b1;
    end

    err_d = err_q;
    if (job_hs) begin
      err_d = 1'b0;
    end else if (rpt_hs && (bus.rpt_status >= RESP_SLVERR)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (job_hs) begin
          state_d = (bus.job_bytes == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        // Skip DRAIN when an error report has already retired the last command.
        if ((rem_d == '0) || err_d) begin
          state_d = (out_d == '0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (out_d == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (done_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    job_ready  = 1'b0;
    cmd_valid  = 1'b0;
    done_valid = 1'b0;
    unique case (state_q)
      StIdle:  job_ready  = 1'b1;
      StIssue: cmd_valid  = (out_q < MaxOut) && !err_q;
      StDone:  done_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      out_q         <= '0;
      err_q         <= 1'b0;
      done_bytes_q  <= '0;
      done_status_q <= RESP_OKAY;
    end else begin
      rem_q <= rem_d;
      out_q <= out_d;
      err_q <= err_d;
      if (job_hs) begin
        src_q         <= bus.job_src_addr;
        dst_q         <= bus.job_dst_addr;
        done_bytes_q  <= '0;
        done_status_q <= RESP_OKAY;
      end else begin
        if (cmd_hs) begin
          src_q <= src_q + ADDRESS_BITS'(chunk);
          dst_q <= dst_q + ADDRESS_BITS'(chunk);
        end
        if (rpt_hs) begin
          done_bytes_q <= done_bytes_q + JOB_LENGTH_BITS'(bus.rpt_bytes);
          if (bus.rpt_status > done_status_q) begin
            done_status_q <= bus.rpt_status;
          end
        end
      end
    end
  end

  assign bus.job_ready    = job_ready;
  assign bus.cmd_src_addr = src_q;
  assign bus.cmd_dst_addr = dst_q;
  assign bus.cmd_bytes    = LENGTH_BITS'(chunk);
  assign bus.cmd_valid    = cmd_valid;
  assign bus.rpt_ready    = rpt_ready;
  assign bus.done_bytes   = done_bytes_q;
  assign bus.done_status  = done_status_q;
  assign bus.done_valid   = done_valid;
  assign bus.busy         = (state_q != StIdle);

endmodule

// File: tb/tb_axi_mdma_seq.sv
// Self-checking bench for axi_mdma_seq: a chunk-list model of each job plus a report
// scoreboard, driven by directed scenarios and randomized responders.
module tb_axi_mdma_seq;
  import axi_mdma_pkg::*;

  localparam int unsigned AB   = 32;
  localparam int unsigned LB   = 16;
  localparam int unsigned JB   = 32;
  localparam int unsigned MAXC = 4096;
  localparam int unsigned MAXO = 4;

  typedef struct packed {
    logic [AB-1:0] src;
    logic [AB-1:0] dst;
    logic [LB-1:0] len;
  } cmd_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi_mdma_seq_if #(.ADDRESS_BITS(AB), .LENGTH_BITS(LB), .JOB_LENGTH_BITS(JB)) bus ();

  axi_mdma_seq #(
    .ADDRESS_BITS   (AB),
    .LENGTH_BITS    (LB),
    .JOB_LENGTH_BITS(JB),
    .MAX_CMD_BYTES  (MAXC),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  cmd_t exp_q[$];

  // Reset-state snapshot: job_ready, cmd_valid, rpt_ready, done_valid, busy, cmd_*, done_*.
  logic [118:0] rst_obs;
  logic [118:0] rst_exp;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Reference split: consecutive chunks of at most MAXC, addresses advancing modulo 2^AB.
  task automatic model_cmds(input logic [AB-1:0] s, input logic [AB-1:0] d,
                            input logic [JB-1:0] n);
    longint rem;
    longint c;
    cmd_t e;
    exp_q.delete();
    rem = longint'(n);
    while (rem > 0) begin
      c = (rem > longint'(MAXC)) ? longint'(MAXC) : rem;
      e.src = s;
      e.dst = d;
      e.len = LB'(c);
      exp_q.push_back(e);
      s = s + AB'(c);
      d = d + AB'(c);
      rem = rem - c;
    end
  endtask

  task automatic start_job(input logic [AB-1:0] s, input logic [AB-1:0] d,
                           input logic [JB-1:0] n);
    bus.job_src_addr = s;
    bus.job_dst_addr = d;
    bus.job_bytes    = n;
    bus.job_valid    = 1'b1;
    tick();
    bus.job_valid    = 1'b0;
  endtask

  task automatic test_reset();
    bus.job_src_addr = '0;
    bus.job_dst_addr = '0;
    bus.job_bytes    = '0;
    bus.job_valid    = 1'b0;
    bus.cmd_ready    = 1'b0;
    bus.rpt_bytes    = '0;
    bus.rpt_status   = RESP_OKAY;
    bus.rpt_valid    = 1'b0;
    bus.done_ready   = 1'b0;
    #2 aresetn = 1'b0;
    #3;
    rst_obs = {bus.job_ready, bus.cmd_valid, bus.rpt_ready, bus.done_valid, bus.busy,
               bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes, bus.done_bytes,
               bus.done_status};
    n_checks++;
    if (rst_obs !== rst_exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", rst_obs, rst_exp);
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    tick();
  endtask

  // Generic job runner with randomized cmd/rpt readiness and done back-pressure.
  task automatic run_job(input logic [AB-1:0] s, input logic [AB-1:0] d,
                         input logic [JB-1:0] n, input int unsigned rdy_pct,
                         input int stall, input bit exok, input string tag);
    cmd_t got[$];
    cmd_t pend[$];
    cmd_t c;
    logic [JB-1:0] exp_bytes;
    logic [1:0] exp_st;
    int cyc;
    int last_rpt;
    bit seen_done;
    exp_bytes = '0;
    exp_st    = RESP_OKAY;
    cyc       = 0;
    last_rpt  = -10;
    seen_done = 1'b0;
    model_cmds(s, d, n);
    start_job(s, d, n);
    c = exp_q[0];
    for (int i = 0; i < stall; i++) begin
      bus.cmd_ready = 1'b0;
      n_checks++;
      if ({bus.cmd_valid, bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes} !== {1'b1, c})
        begin
        n_fail++;
        $display("FAIL %s stall_cycle%0d: got %h required %h", tag, i,
                 {bus.cmd_valid, bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes}, {1'b1, c});
      end
      tick();
    end
    while (!seen_done && cyc < 4000) begin
      if (bus.done_valid) begin
        seen_done = 1'b1;
        n_checks++;
        if (cyc != last_rpt + 1) begin
          n_fail++;
          $display("FAIL %s done_latency: got cycle %0d required %0d", tag, cyc, last_rpt + 1);
        end
        bus.done_ready = 1'b0;
        repeat ($urandom_range(3)) tick();
        n_checks++;
        if ({bus.done_valid, bus.done_bytes, bus.done_status} !== {1'b1, exp_bytes, exp_st})
          begin
          n_fail++;
          $display("FAIL %s done: got %h required %h", tag,
                   {bus.done_valid, bus.done_bytes, bus.done_status}, {1'b1, exp_bytes, exp_st});
        end
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        n_checks++;
        if ({bus.job_ready, bus.busy, bus.done_valid} !== 3'b100) begin
          n_fail++;
          $display("FAIL %s back_to_idle: got %b required 100", tag,
                   {bus.job_ready, bus.busy, bus.done_valid});
        end
      end else begin
        bus.cmd_ready = ($urandom_range(99) < rdy_pct);
        bus.rpt_valid = 1'b0;
        if (pend.size() > 0 && $urandom_range(99) < rdy_pct) begin
          bus.rpt_valid  = 1'b1;
          bus.rpt_bytes  = pend[0].len;
          bus.rpt_status = exok ? 2'($urandom_range(1)) : RESP_OKAY;
        end
        if (bus.rpt_valid && bus.rpt_ready) begin
          c = pend.pop_front();
          exp_bytes = exp_bytes + JB'(bus.rpt_bytes);
          if (bus.rpt_status > exp_st) exp_st = bus.rpt_status;
          last_rpt = cyc;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          c = {bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes};
          got.push_back(c);
          pend.push_back(c);
        end
        tick();
        cyc++;
      end
    end
    bus.cmd_ready = 1'b0;
    bus.rpt_valid = 1'b0;
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no done_valid within %0d cycles", tag, cyc);
    end
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s cmd_count: got %0d required %0d", tag, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cmd%0d: got %h required %h", tag, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_basic();
    run_job(32'h0000_0000, 32'h0000_1000, 32'd10000, 100, 0, 1'b0, "basic");
  endtask

  task automatic test_zero_length();
    start_job(32'h1234_0000, 32'h5678_0000, '0);
    n_checks++;
    if ({bus.done_valid, bus.cmd_valid, bus.done_bytes, bus.done_status} !== {2'b10, 34'd0})
      begin
      n_fail++;
      $display("FAIL zero_len_done: got %h required %h",
               {bus.done_valid, bus.cmd_valid, bus.done_bytes, bus.done_status},
               {2'b10, 34'd0});
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    n_checks++;
    if ({bus.job_ready, bus.cmd_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_len_idle: got %b required 10", {bus.job_ready, bus.cmd_valid});
    end
  endtask

  task automatic test_stall();
    run_job(32'h0000_0800, 32'h4000_0000, JB'($urandom_range(5 * MAXC, 2 * MAXC + 1)),
            100, 5, 1'b0, "stall");
  endtask

  task automatic test_limit();
    cmd_t got[$];
    logic [JB-1:0] n;
    int k;
    n = JB'(7 * MAXC + 1 + $urandom_range(MAXC - 1));
    model_cmds(32'h0010_0000, 32'h0080_0000, n);
    start_job(32'h0010_0000, 32'h0080_0000, n);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_valid) got.push_back({bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes});
      tick();
    end
    n_checks++;
    if ({got.size(), bus.cmd_valid, bus.rpt_ready} !== {MAXO, 2'b01}) begin
      n_fail++;
      $display("FAIL limit_stop: got %0d cmds valid=%b required %0d cmds valid=0",
               got.size(), bus.cmd_valid, MAXO);
    end
    k = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rpt_valid  = 1'b1;
      bus.rpt_bytes  = got[k].len;
      bus.rpt_status = RESP_OKAY;
      k++;
      tick();
      bus.rpt_valid = 1'b0;
      n_checks++;
      if (bus.cmd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL limit_reissue%0d: cmd_valid got %b required 1", i, bus.cmd_valid);
      end
      if (bus.cmd_valid) got.push_back({bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes});
      tick();
      n_checks++;
      if (bus.cmd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL limit_refill%0d: cmd_valid got %b required 0", i, bus.cmd_valid);
      end
    end
    while (k < got.size()) begin
      bus.rpt_valid = 1'b1;
      bus.rpt_bytes = got[k].len;
      k++;
      tick();
    end
    bus.rpt_valid = 1'b0;
    n_checks++;
    if ({bus.done_valid, bus.done_bytes, bus.done_status} !== {1'b1, n, RESP_OKAY}) begin
      n_fail++;
      $display("FAIL limit_done: got %h required %h",
               {bus.done_valid, bus.done_bytes, bus.done_status}, {1'b1, n, RESP_OKAY});
    end
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL limit_cmd_count: got %0d required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL limit_cmd%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
  endtask

  task automatic test_error_abort();
    cmd_t got[$];
    logic [JB-1:0] n;
    logic [JB-1:0] sum;
    logic [1:0] st;
    int extra;
    n = JB'(5 * MAXC + 1 + $urandom_range(MAXC - 1));
    model_cmds(32'h0200_0000, 32'h0300_0000, n);
    start_job(32'h0200_0000, 32'h0300_0000, n);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_valid) got.push_back({bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes});
      tick();
    end
    bus.cmd_ready = 1'b0;
    sum = '0;
    st  = RESP_OKAY;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.cmd_ready = 1'b1;
        extra = 0;
        for (int j = 0; j < 5; j++) begin
          if (bus.cmd_valid) extra++;
          tick();
        end
        n_checks++;
        if (extra != 0) begin
          n_fail++;
          $display("FAIL error_no_new_cmd: got %0d extra cmds required 0", extra);
        end
      end
      bus.rpt_valid  = 1'b1;
      bus.rpt_bytes  = LB'($urandom_range(MAXC, 1));
      bus.rpt_status = (i == 2) ? RESP_SLVERR : 2'($urandom_range(1));
      sum = sum + JB'(bus.rpt_bytes);
      if (bus.rpt_status > st) st = bus.rpt_status;
      tick();
      bus.rpt_valid = 1'b0;
    end
    n_checks++;
    if ({bus.done_valid, bus.done_bytes, bus.done_status} !== {1'b1, sum, st}) begin
      n_fail++;
      $display("FAIL error_done: got %h required %h",
               {bus.done_valid, bus.done_bytes, bus.done_status}, {1'b1, sum, st});
    end
    n_checks++;
    if (got.size() != MAXO) begin
      n_fail++;
      $display("FAIL error_cmd_count: got %0d required %0d", got.size(), MAXO);
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL error_cmd%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    bus.cmd_ready  = 1'b0;
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
  endtask

  task automatic test_random_jobs();
    logic [AB-1:0] s;
    for (int j = 0; j < 4; j++) begin
      s = AB'($urandom) | 32'hFFFF_8000;
      run_job(s, AB'($urandom), JB'($urandom_range(20000, 1)), 60, 0, 1'b1, "random");
    end
  endtask

  task automatic test_simul_and_reset();
    cmd_t got[$];
    model_cmds(32'h0000_0000, 32'h0001_0000, JB'(8 * MAXC));
    start_job(32'h0000_0000, 32'h0001_0000, JB'(8 * MAXC));
    for (int i = 0; i < 10 && got.size() < 3; i++) begin
      bus.cmd_ready = 1'b1;
      if (bus.cmd_valid) got.push_back({bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes});
      tick();
    end
    bus.cmd_ready = 1'b1;
    bus.rpt_valid = 1'b1;
    bus.rpt_bytes = got[0].len;
    n_checks++;
    if ({got.size(), bus.cmd_valid, bus.rpt_ready} !== {32'd3, 2'b11}) begin
      n_fail++;
      $display("FAIL simul_setup: got %0d cmds valid=%b rpt_ready=%b required 3 1 1",
               got.size(), bus.cmd_valid, bus.rpt_ready);
    end
    tick();
    bus.rpt_valid = 1'b0;
    n_checks++;
    if (bus.cmd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_count3: cmd_valid got %b required 1", bus.cmd_valid);
    end
    tick();
    n_checks++;
    if ({bus.cmd_valid, bus.rpt_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL simul_count4: valid/rpt_ready got %b required 01",
               {bus.cmd_valid, bus.rpt_ready});
    end
    bus.cmd_ready = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    rst_obs = {bus.job_ready, bus.cmd_valid, bus.rpt_ready, bus.done_valid, bus.busy,
               bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_bytes, bus.done_bytes,
               bus.done_status};
    n_checks++;
    if (rst_obs !== rst_exp) begin
      n_fail++;
      $display("FAIL mid_job_reset: got %h required %h", rst_obs, rst_exp);
    end
    @(negedge aclk) aresetn = 1'b1;
    tick();
    n_checks++;
    if ({bus.job_ready, bus.busy, bus.cmd_valid, bus.rpt_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL after_reset_idle: got %b required 1000",
               {bus.job_ready, bus.busy, bus.cmd_valid, bus.rpt_ready});
    end
  endtask

  initial begin
    rst_exp = {1'b1, 118'd0};
    test_reset();
    test_basic();
    test_zero_length();
    test_stall();
    test_limit();
    test_error_abort();
    test_random_jobs();
    test_simul_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_mdma_seq.md
# axi_mdma_seq

Job sequencer on the command/report side of `axi_mdma`. It accepts one large copy job (32-bit length) and splits it into `axi_mdma` commands of at most MAX_CMD_BYTES each. It keeps up to MAX_OUTSTANDING commands in flight, consumes the per-command reports, and returns one aggregated completion per job. It replaces the bench/software driving `cmd_*` and `rpt_*` directly.

## Interface
- ADDRESS_BITS, 32, width of src/dst addresses (both sides).
- LENGTH_BITS, 16, width of `cmd_bytes`/`rpt_bytes`; must match `axi_mdma`.
- JOB_LENGTH_BITS, 32, width of `job_bytes`/`done_bytes`.
- MAX_CMD_BYTES, 4096, largest single command; must be ≤ 2^LENGTH_BITS−1 and ≥ 1.
- MAX_OUTSTANDING, 4, commands issued but not yet reported; 1..15.

Ports:
- aclk  in  1  clock; the block uses clock aclk.
- aresetn  in  1  reset; the block uses reset aresetn, asynchronous, active-low.
- job_src_addr  in  ADDRESS_BITS  job source byte address.
- job_dst_addr  in  ADDRESS_BITS  job destination byte address.
- job_bytes  in  JOB_LENGTH_BITS  job length in bytes.
- job_valid / job_ready  in / out  1  job handshake.
- cmd_src_addr  out  ADDRESS_BITS  to `axi_mdma`.
- cmd_dst_addr  out  ADDRESS_BITS  to `axi_mdma`.
- cmd_bytes  out  LENGTH_BITS  to `axi_mdma`.
- cmd_valid / cmd_ready  out / in  1  command handshake.
- rpt_bytes  in  LENGTH_BITS  from `axi_mdma`.
- rpt_status  in  2  from `axi_mdma`, AXI resp encoding.
- rpt_valid / rpt_ready  in / out  1  report handshake; rpt addresses are not used.
- done_bytes  out  JOB_LENGTH_BITS  sum of reported bytes.
- done_status  out  2  worst (max) reported status.
- done_valid / done_ready  out / in  1  completion handshake.
- busy  out  1  state ≠ IDLE.

## Operation
States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `job_ready = 1`.
  - On `job_valid & job_ready`, latch src, dst and remaining = `job_bytes`; clear `done_bytes`, `done_status` and the error flag.
  - Go to DONE if `job_bytes == 0`, else to ISSUE.
- **ISSUE**
  - `cmd_valid = 1` whenever `outstanding < MAX_OUTSTANDING`.
  - `cmd_bytes = min(remaining, MAX_CMD_BYTES)`.
  - `cmd_*` are registered and stay stable while `cmd_valid & !cmd_ready`.
  - On each handshake:
    - src += chunk and dst += chunk, modulo 2^ADDRESS_BITS (wrap is silent).
    - remaining −= chunk.
    - outstanding++.
  - When remaining reaches 0, or the error flag is set, go to DRAIN.
  - An error arriving while `cmd_valid` is high may complete that pending handshake. No new command is raised afterwards.
- **DRAIN**
  - No commands are issued.
  - When `outstanding == 0`, go to DONE.
- **Reports**
  - `rpt_ready = (outstanding != 0)` in every state.
  - On each handshake:
    - outstanding−−.
    - `done_bytes += rpt_bytes`.
    - `done_status = max(done_status, rpt_status)`.
    - If `rpt_status ≥ 2` (SLVERR/DECERR), set the error flag.
  - A command handshake and a report handshake in the same cycle leave outstanding unchanged.
- **DONE**
  - `done_valid = 1`; `done_*` are held until `done_ready`, then go to IDLE.
- Reports are assumed in issue order; the block only counts them and never matches addresses.

## Timing
- Reset values:
  - `job_ready` = 1 (state IDLE).
  - `cmd_valid`, `rpt_ready`, `done_valid`, `busy` = 0.
  - `cmd_*`, `done_bytes`, `done_status` = 0.
  - outstanding = 0.
- Latencies:
  - First `cmd_valid` appears 1 cycle after job accept.
  - Back-to-back commands run one per cycle while `cmd_ready = 1` and the outstanding limit is not reached.
  - When a report frees a slot at the limit, `cmd_valid` re-asserts the next cycle.
  - `done_valid` asserts 1 cycle after the last report handshake.
  - For a zero-length job, `done_valid` asserts 1 cycle after accept.
  - `job_ready` returns 1 the cycle after `done_valid & done_ready`.
- Reset mid-job: all state and counts are lost immediately. `axi_mdma` must share aresetn, so no stale reports arrive.
- Arithmetic widths:
  - `done_bytes` accumulates at JOB_LENGTH_BITS and wraps without saturation.
  - outstanding counter is ⌈log2(MAX_OUTSTANDING+1)⌉ bits.

## Structure
- Shared package `axi_mdma_pkg`:
  - resp constants RESP_OKAY=0, RESP_EXOKAY=1, RESP_SLVERR=2, RESP_DECERR=3.
  - state typedef for IDLE/ISSUE/DRAIN/DONE.
- Single module with no sub-module. The chunk min/compare is inline; the outstanding counter is a plain up/down register.

## Test plan
- Job src=0x0000, dst=0x1000, bytes=10000, always-ready responder:
  - 3 cmds: (0x0000,0x1000,4096), (0x1000,0x2000,4096), (0x2000,0x3000,1808).
  - `done_bytes` = 10000, `done_status` = 0.
- `job_bytes` = 0:
  - no `cmd_valid` ever.
  - `done_valid` 1 cycle after accept, `done_bytes` = 0, `done_status` = 0.
- MAX_OUTSTANDING=4, 8 chunks, reports withheld:
  - exactly 4 cmds issued, then `cmd_valid` = 0.
  - each released report lets the next cmd issue one cycle later.
- Third report carries status 2 on a 6-chunk job:
  - no new cmd after the in-flight ones.
  - `done_status` = 2 and `done_bytes` = sum of received `rpt_bytes` only.
- `cmd_ready` held low 5 cycles during ISSUE: `cmd_*` stable for all 5 cycles and handshake count unchanged.
- Simultaneous cmd and rpt handshake with outstanding=3: outstanding stays 3. Then aresetn pulsed mid-job: all outputs return to reset values and `job_ready` = 1.
